// File: rtl/padc_pkg.sv
// Shared types for the pipelined-ADC conversion controller.
// Stage count, code width, stage-code type, FSM states, 1.5-bit saturation.
package padc_pkg;

  localparam int NSTAGE = 7;
  localparam int CODE_W = 8;

  typedef logic [1:0] stage_code_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DRAIN
  } state_t;

  // 2'b11 is not a legal 1.5-bit decision; treat it as the top code.
  function automatic logic [1:0] sat_code(
    input stage_code_t c
  );
    return (c == 2'b11) ? 2'b10 : c;
  endfunction

endpackage

// File: rtl/padc_conv_ctrl_if.sv
// Corrected-code output stream (valid/ready).
// master: drives code_data/code_valid, receives code_ready.
interface padc_conv_ctrl_if;
  import padc_pkg::*;

  logic [CODE_W-1:0] code_data;
  logic              code_valid;
  logic              code_ready;

  modport master (
    output code_data,
    output code_valid,
    input  code_ready
  );

  modport slave (
    input  code_data,
    input  code_valid,
    output code_ready
  );

endinterface

// File: rtl/padc_conv_fifo.sv
// Synchronous FIFO for corrected codes.
// Ports: clk, rstn, push/din, pop/dout, full, empty.
module padc_conv_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_pop;
  logic          do_push;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign dout  = mem[rd_ptr];

  // A pop frees the slot, so a push into a full FIFO is
  // accepted when a pop happens on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/padc_conv_ctrl.sv
// Pipelined-ADC conversion controller: aligns stage codes, corrects,
// buffers. Ports: clk, rstn, dig_raw, start/stop/burst_len, code stream,
// busy, overflow/illegal status, clr_status.
module padc_conv_ctrl
  import padc_pkg::*;
#(
  parameter int NSTAGE     = padc_pkg::NSTAGE,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  stage_code_t             dig_raw [NSTAGE],
  input  logic                    start,
  input  logic                    stop,
  input  logic [7:0]              burst_len,
  output logic                    busy,
  padc_conv_ctrl_if.master        code,
  output logic                    overflow,
  output logic                    illegal,
  input  logic                    clr_status
);

  localparam logic [7:0] FILL_LAST = 8'(NSTAGE - 1);

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        cnt;
  logic [7:0]        cnt_nxt;
  logic [7:0]        len_q;
  logic [7:0]        len_nxt;
  logic              push;
  stage_code_t       aligned [NSTAGE];
  logic [CODE_W-1:0] corr;
  logic              bad;
  logic              full;
  logic              empty;

  // Stage g reflects sample k one edge later than stage g-1, so
  // delay it by NSTAGE-1-g registers to line up on one sample.
  for (genvar g = 0; g < NSTAGE; g++) begin : g_align
    localparam int L = NSTAGE - 1 - g;
    if (L == 0) begin : g_direct
      assign aligned[g] = dig_raw[g];
    end else begin : g_dly
      stage_code_t sr [L];
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int j = 0; j < L; j++) sr[j] <= '0;
        end else begin
          sr[0] <= dig_raw[g];
          for (int j = 1; j < L; j++) sr[j] <= sr[j-1];
        end
      end
      assign aligned[g] = sr[L-1];
    end
  end

  always_comb begin
    corr = '0;
    bad  = 1'b0;
    for (int i = 0; i < NSTAGE; i++) begin
      corr = corr + (CODE_W'(sat_code(aligned[i]))
                     << (NSTAGE - 1 - i));
      bad  = bad | (aligned[i] == 2'b11);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      cnt   <= '0;
      len_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      len_q <= len_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    len_nxt   = len_q;
    push      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FILL;
          cnt_nxt   = '0;
          len_nxt   = burst_len;
        end
      end
      S_FILL: begin
        if (stop) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == FILL_LAST) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      S_RUN: begin
        // The exit edge still pushes its sample.
        push    = 1'b1;
        cnt_nxt = cnt + 8'd1;
        if (stop || (len_q != '0 && cnt_nxt == len_q)) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (empty) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (state != S_IDLE);

  padc_conv_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CODE_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (corr),
    .pop   (code.code_ready),
    .dout  (code.code_data),
    .full  (full),
    .empty (empty)
  );

  assign code.code_valid = !empty;

  // Set has priority over clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      if (push && full && !code.code_ready) overflow <= 1'b1;
      else if (clr_status)                  overflow <= 1'b0;
      if (push && bad)     illegal <= 1'b1;
      else if (clr_status) illegal <= 1'b0;
    end
  end

endmodule

// File: tb/tb_padc_conv_ctrl.sv
// Scoreboard bench for padc_conv_ctrl: expected codes queued at stimulus,
// popped and compared by a monitor on each accepted transfer.
module tb_padc_conv_ctrl;
  import padc_pkg::*;

  localparam int NS = padc_pkg::NSTAGE;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  stage_code_t dig_raw [NS];
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  burst_len = '0;
  logic        busy;
  logic        overflow;
  logic        illegal;
  logic        clr_status = 1'b0;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  padc_conv_ctrl_if cif();

  padc_conv_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .dig_raw    (dig_raw),
    .start      (start),
    .stop       (stop),
    .burst_len  (burst_len),
    .busy       (busy),
    .code       (cif),
    .overflow   (overflow),
    .illegal    (illegal),
    .clr_status (clr_status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: a transfer is committed at the next rising edge.
  always @(negedge clk) begin
    if (rstn && cif.code_valid && cif.code_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_code: got %0d expected none",
                 cif.code_data);
      end else begin
        chk("code_data", int'(cif.code_data), exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input stage_code_t v);
    for (int i = 0; i < NS; i++) dig_raw[i] = v;
  endtask

  task automatic start_burst(input int len);
    burst_len = 8'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_n(input int n, input int v);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic wait_idle(input string nm);
    for (int n = 0; n < 300 && busy; n++) tick();
    chk(nm, int'(busy), 0);
  endtask

  task automatic clear_status();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_all(2'd0);
    cif.code_ready = 1'b1;
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(cif.code_valid), 0);
    chk("rst_data", int'(cif.code_data), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_ill", int'(illegal), 0);
    rstn = 1'b1;
    tick();

    // Constant mid code, three samples, latency check.
    set_all(2'd1);
    expect_n(3, 127);
    start_burst(3);
    chk("busy_after_start", int'(busy), 1);
    repeat (7) tick();
    chk("valid_before_e8", int'(cif.code_valid), 0);
    tick();
    chk("valid_after_e8", int'(cif.code_valid), 1);
    wait_idle("idle_034");
    chk("valid_034_end", int'(cif.code_valid), 0);

    // Stage weighting.
    set_all(2'd0);
    dig_raw[0] = 2'd2;
    expect_n(2, 128);
    start_burst(2);
    wait_idle("idle_128");
    set_all(2'd2);
    expect_n(2, 254);
    start_burst(2);
    wait_idle("idle_254");
    set_all(2'd0);
    expect_n(2, 0);
    start_burst(2);
    wait_idle("idle_0");

    // Alignment: sample k=4 is pushed at E10 (third push).
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(254);
    exp_q.push_back(0);
    exp_q.push_back(0);
    start_burst(5);
    for (int n = 1; n <= 12; n++) begin
      for (int i = 0; i < NS; i++)
        dig_raw[i] = (n == 4 + i) ? 2'd2 : 2'd0;
      tick();
    end
    set_all(2'd0);
    wait_idle("idle_align");

    // Overflow: four stored, two dropped.
    cif.code_ready = 1'b0;
    set_all(2'd1);
    expect_n(4, 127);
    start_burst(6);
    repeat (11) tick();
    chk("ovf_before_drop", int'(overflow), 0);
    repeat (2) tick();
    chk("ovf_set", int'(overflow), 1);
    chk("busy_drain", int'(busy), 1);
    chk("valid_drain", int'(cif.code_valid), 1);
    cif.code_ready = 1'b1;
    wait_idle("idle_ovf");
    chk("q_empty_ovf", exp_q.size(), 0);
    clear_status();
    chk("ovf_clr", int'(overflow), 0);

    // Illegal code on stage 3 counts as 2 -> 16.
    set_all(2'd0);
    dig_raw[3] = 2'b11;
    expect_n(2, 16);
    start_burst(2);
    wait_idle("idle_ill");
    chk("ill_set", int'(illegal), 1);
    clear_status();
    chk("ill_clr", int'(illegal), 0);
    expect_n(1, 16);
    start_burst(1);
    repeat (7) tick();
    chk("ill_before_e8", int'(illegal), 0);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("ill_set_wins", int'(illegal), 1);
    wait_idle("idle_ill2");
    clear_status();

    // Continuous burst, stop sampled at E17 -> ten codes.
    set_all(2'd1);
    expect_n(10, 127);
    start_burst(0);
    repeat (16) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_idle("idle_stop");
    chk("q_empty_stop", exp_q.size(), 0);

    // Reset mid-RUN discards everything.
    cif.code_ready = 1'b0;
    start_burst(0);
    repeat (10) tick();
    chk("valid_pre_rst", int'(cif.code_valid), 1);
    rstn = 1'b0;
    #1;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_valid", int'(cif.code_valid), 0);
    chk("rst_mid_data", int'(cif.code_data), 0);
    tick();
    rstn = 1'b1;
    cif.code_ready = 1'b1;
    repeat (4) tick();
    chk("post_rst_valid", int'(cif.code_valid), 0);
    chk("post_rst_busy", int'(busy), 0);
    chk("q_empty_end", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/padc_conv_ctrl.md
PADC_CONV_CTRL -- requirements
Module: padc_conv_ctrl

Interface
REQ-001 Parameter NSTAGE, default 7: number of 1.5-bit pipeline stages feeding dig_raw.
REQ-002 Parameter FIFO_DEPTH, default 4: output buffer depth in corrected codes, power of two.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 Port dig_raw  input  [1:0] x NSTAGE unpacked  per-stage raw code; stage i reflects sample k at edge k+i.
REQ-006 Port start  input  1  single-cycle request to begin a conversion burst.
REQ-007 Port stop  input  1  single-cycle request to end the burst early.
REQ-008 Port burst_len  input  8  samples per burst; 0 = continuous until stop.
REQ-009 Port busy  output  1  high in any state other than IDLE.
REQ-010 Port code_data  output  8  corrected code at FIFO head, range 0..254.
REQ-011 Port code_valid  output  1  FIFO non-empty.
REQ-012 Port code_ready  input  1  consumer accept; transfer when code_valid and code_ready both high.
REQ-013 Port overflow  output  1  sticky: a code was dropped because the FIFO was full.
REQ-014 Port illegal  output  1  sticky: a raw code 2'b11 was consumed.
REQ-015 Port clr_status  input  1  clears overflow and illegal.

Function
REQ-016 Alignment: stage i code passes through NSTAGE-1-i registers, so all NSTAGE aligned codes belong to one sample; alignment registers run in every state.
REQ-017 Correction: code = sum over i of d_i * 2^(NSTAGE-1-i), with d_i the aligned code for stage i; 2'b11 saturates to 2; the result is unsigned, 8 bits, with no overflow possible.
REQ-018 FSM states: IDLE, FILL, RUN, DRAIN.
REQ-019 IDLE: start -> FILL; stop is ignored.
REQ-020 FILL: count NSTAGE cycles, then -> RUN; no FIFO pushes occur; stop -> IDLE.
REQ-021 start sampled at edge E0: FILL spans E1..E7, first push at E8, code_valid high after E8.
REQ-022 RUN: push one corrected code per cycle and increment the sample counter whether the push is accepted or dropped.
REQ-023 RUN exit: the counter reaching a non-zero burst_len, or stop, -> DRAIN; the sample at the exit edge is the last one pushed.
REQ-024 DRAIN: no pushes; -> IDLE when the FIFO is empty; code_valid keeps presenting the remaining entries.
REQ-025 start while busy is ignored; burst_len is latched at start.
REQ-026 Push when the FIFO is full and no pop occurs in the same cycle: the code is dropped and overflow is set; with a simultaneous pop the push is accepted.
REQ-027 Pop on an empty FIFO has no effect; code_data is don't-care while code_valid is low.
REQ-028 illegal is set when any consumed aligned code equals 2'b11 in RUN.
REQ-029 clr_status clears overflow and illegal; when a set event occurs in the same cycle, set wins.

Reset
REQ-030 rstn low: state IDLE, counters 0, alignment registers 0, FIFO empty, busy/code_valid/overflow/illegal 0, code_data 0.
REQ-031 Reset mid-burst aborts immediately; the FIFO contents are discarded.

Structure
REQ-032 Package padc_pkg: NSTAGE, CODE_W=8, stage-code typedef logic [1:0], FSM state enum.
REQ-033 One sub-module padc_conv_fifo (synchronous FIFO, push/pop/full/empty); the FSM, alignment and correction stay in padc_conv_ctrl.

Verification
REQ-034 All stages 2'b01 constant, burst_len=3, code_ready=1 -> three codes 127, first valid after E8, busy low after the FIFO empties.
REQ-035 Stage 0=2, others 0 -> 128; all stages 2 -> 254; all 0 -> 0.
REQ-036 Alignment: drive 2 on stage i only at edge k+i for one sample k -> exactly one code 254, all others 0.
REQ-037 code_ready=0, burst_len=6 -> 4 codes stored, 2 dropped, overflow=1; raise code_ready -> 4 codes drain, then IDLE.
REQ-038 Stage 3 driven 2'b11 in RUN -> that code counts as 2, illegal=1; clr_status pulse -> illegal=0; clr_status coinciding with a new 2'b11 -> illegal stays 1.
REQ-039 burst_len=0 with stop after 10 samples -> 10 codes; rstn pulse mid-RUN -> busy=0, code_valid=0, FIFO empty.
